// File: rtl/fetch_unit_pkg.sv
// Shared opcode definitions for the fetch path and the decode path.
// Instruction word layout: opcode in [15:12], branch target in [7:0].
package fetch_unit_pkg;

   localparam int AW = 8;
   localparam int DW = 16;

   localparam logic [3:0] OP_NOP   = 4'h0;
   localparam logic [3:0] OP_INC   = 4'h1;
   localparam logic [3:0] OP_DEC   = 4'h2;
   localparam logic [3:0] OP_COMP  = 4'h3;
   localparam logic [3:0] OP_CHECK = 4'h4;
   localparam logic [3:0] OP_LOAD  = 4'h5;
   localparam logic [3:0] OP_STORE = 4'h6;
   localparam logic [3:0] OP_JMP   = 4'h8;
   localparam logic [3:0] OP_JNZ   = 4'h9;
   localparam logic [3:0] OP_JNO   = 4'hA;

   function automatic logic [3:0] opcode_of(input logic [DW-1:0] w);
      return w[DW-1:DW-4];
   endfunction

endpackage

// File: rtl/branch_classify.sv
// Decodes the opcode and target fields of the fetched word into branch flags.
module branch_classify
   import fetch_unit_pkg::*;
(
   input  logic [3:0]    i_opcode,
   input  logic [AW-1:0] i_target,
   output logic          o_is_jmp,
   output logic          o_is_jnz,
   output logic          o_is_jno,
   output logic [AW-1:0] o_target
);

   assign o_is_jmp = (i_opcode == OP_JMP);
   assign o_is_jnz = (i_opcode == OP_JNZ);
   assign o_is_jno = (i_opcode == OP_JNO);
   assign o_target = i_target;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: feeds decode through a one-entry valid/ready register,
// resolves jumps locally and stalls conditional branches until flag_eq is final.
module fetch_unit
   import fetch_unit_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   output logic [AW-1:0] pc,
   input  logic [DW-1:0] op_in,
   output logic [DW-1:0] ir,
   output logic          ir_valid,
   input  logic          ir_ready,
   input  logic          ex_busy,
   input  logic          flag_eq,
   output logic          halted,
   output logic [DW-1:0] insn_cnt
);

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      WAIT = 2'd1,
      HALT = 2'd2
   } state_t;

   state_t        r_state;
   logic [AW-1:0] r_pc;
   logic [DW-1:0] r_ir;
   logic          r_ir_valid;
   logic          r_halted;
   logic [DW-1:0] r_cnt;
   logic [AW-1:0] r_br_tgt;
   logic          r_br_jno;

   logic          w_is_jmp;
   logic          w_is_jnz;
   logic          w_is_jno;
   logic [AW-1:0] w_target;
   logic [AW-1:0] w_pc_inc;
   logic          w_xfer;
   logic          w_slot_free;
   logic          w_taken;

   branch_classify u_classify (
      .i_opcode (op_in[DW-1:DW-4]),
      .i_target (op_in[AW-1:0]),
      .o_is_jmp (w_is_jmp),
      .o_is_jnz (w_is_jnz),
      .o_is_jno (w_is_jno),
      .o_target (w_target)
   );

   assign w_xfer      = r_ir_valid & ir_ready;
   assign w_slot_free = ~r_ir_valid | ir_ready;
   assign w_pc_inc    = r_pc + 1'b1;
   // JNO branches on "not equal", JNZ on "equal".
   assign w_taken     = r_br_jno ? ~flag_eq : flag_eq;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= RUN;
         r_pc       <= '0;
         r_ir       <= '0;
         r_ir_valid <= 1'b0;
         r_halted   <= 1'b0;
         r_cnt      <= '0;
         r_br_tgt   <= '0;
         r_br_jno   <= 1'b0;
      end else begin
         if (w_xfer && r_cnt != {DW{1'b1}})
            r_cnt <= r_cnt + 1'b1;

         case (r_state)
            RUN: begin
               if (w_slot_free) begin
                  if (w_is_jmp) begin
                     r_ir_valid <= 1'b0;
                     if (w_target == r_pc) begin
                        r_state  <= HALT;
                        r_halted <= 1'b1;
                     end else begin
                        r_pc <= w_target;
                     end
                  end else if (w_is_jnz || w_is_jno) begin
                     r_ir_valid <= 1'b0;
                     r_br_tgt   <= w_target;
                     r_br_jno   <= w_is_jno;
                     r_state    <= WAIT;
                  end else begin
                     r_ir       <= op_in;
                     r_ir_valid <= 1'b1;
                     r_pc       <= w_pc_inc;
                  end
               end
            end
            WAIT: begin
               if (!ex_busy) begin
                  // A taken branch onto itself can never make progress.
                  if (w_taken && r_br_tgt == r_pc) begin
                     r_state  <= HALT;
                     r_halted <= 1'b1;
                  end else begin
                     r_pc    <= w_taken ? r_br_tgt : w_pc_inc;
                     r_state <= RUN;
                  end
               end
            end
            HALT: begin
               if (w_xfer)
                  r_ir_valid <= 1'b0;
            end
            default: r_state <= RUN;
         endcase
      end
   end

   assign pc       = r_pc;
   assign ir       = r_ir;
   assign ir_valid = r_ir_valid;
   assign halted   = r_halted;
   assign insn_cnt = r_cnt;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: instruction memory array, cycle-level behavioural model,
// per-cycle compare plus directed scenarios with literal expectations.
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  pc;
   logic [15:0] op_in;
   logic [15:0] ir;
   logic        ir_valid;
   logic        ir_ready = 1'b0;
   logic        ex_busy  = 1'b0;
   logic        flag_eq  = 1'b0;
   logic        halted;
   logic [15:0] insn_cnt;

   logic [15:0] mem [256];
   assign op_in = mem[pc];

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk      (clk),
      .rst      (rst),
      .pc       (pc),
      .op_in    (op_in),
      .ir       (ir),
      .ir_valid (ir_valid),
      .ir_ready (ir_ready),
      .ex_busy  (ex_busy),
      .flag_eq  (flag_eq),
      .halted   (halted),
      .insn_cnt (insn_cnt)
   );

   int n_chk  = 0;
   int n_pass = 0;
   logic [15:0] dq [$];   // words observed crossing to decode

   // behavioural model state
   int          m_pc;
   logic [15:0] m_ir;
   bit          m_v, m_halt, m_wait;
   logic [3:0]  m_kind;
   int          m_tgt;
   int          m_cnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic bit is_br(input logic [15:0] w);
      return (w[15:12] == OP_JMP) || (w[15:12] == OP_JNZ) || (w[15:12] == OP_JNO);
   endfunction

   task automatic model_reset();
      m_pc = 0; m_ir = '0; m_v = 0; m_halt = 0; m_wait = 0;
      m_kind = OP_NOP; m_tgt = 0; m_cnt = 0;
   endtask

   task automatic model_step();
      logic [15:0] w;
      int          tgt;
      bit          take;
      if (rst) return;
      if (m_v && ir_ready && m_cnt < 65535) m_cnt++;
      if (m_halt) begin
         if (ir_ready) m_v = 0;
      end else if (m_wait) begin
         if (!ex_busy) begin
            take = (m_kind == OP_JNZ) ? flag_eq : !flag_eq;
            if (take && m_tgt == m_pc) m_halt = 1;
            else m_pc = take ? m_tgt : (m_pc + 1) % 256;
            m_wait = 0;
         end
      end else if (!m_v || ir_ready) begin
         w   = mem[m_pc];
         tgt = int'(w[7:0]);
         if (w[15:12] == OP_JMP) begin
            m_v = 0;
            if (tgt == m_pc) m_halt = 1;
            else m_pc = tgt;
         end else if (w[15:12] == OP_JNZ || w[15:12] == OP_JNO) begin
            m_v = 0; m_kind = w[15:12]; m_tgt = tgt; m_wait = 1;
         end else begin
            m_ir = w; m_v = 1; m_pc = (m_pc + 1) % 256;
         end
      end
   endtask

   task automatic compare();
      chk("pc", {24'd0, pc}, m_pc);
      chk("ir_valid", {31'd0, ir_valid}, {31'd0, m_v});
      chk("ir", {16'd0, ir}, {16'd0, m_ir});
      chk("halted", {31'd0, halted}, {31'd0, m_halt});
      chk("insn_cnt", {16'd0, insn_cnt}, m_cnt);
      if (ir_valid) chk("ir_not_branch", {31'd0, is_br(ir)}, 32'd0);
   endtask

   task automatic cycle();
      if (ir_valid && ir_ready) dq.push_back(ir);
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      model_reset();
      compare();
   endtask

   task automatic start();
      do_reset();
      cycle();
      rst = 1'b0;
      dq.delete();
   endtask

   task automatic fill_default();
      for (int i = 0; i < 256; i++) mem[i] = {OP_INC, 4'h0, 8'(i)};
   endtask

   initial begin
      #2;
      // reset state and straight-line fetch
      fill_default();
      mem[0] = {OP_COMP, 12'h000};
      mem[2] = {OP_DEC, 12'h002};
      ir_ready = 1; ex_busy = 0; flag_eq = 0;
      do_reset();
      chk("rst_pc", {24'd0, pc}, 0);
      chk("rst_ir", {16'd0, ir}, 0);
      chk("rst_valid", {31'd0, ir_valid}, 0);
      chk("rst_halted", {31'd0, halted}, 0);
      chk("rst_cnt", {16'd0, insn_cnt}, 0);
      cycle();
      rst = 0;
      cycle();
      chk("t1_pc1", {24'd0, pc}, 1);
      chk("t1_valid", {31'd0, ir_valid}, 1);
      chk("t1_ir0", {16'd0, ir}, 32'h3000);
      cycle(); chk("t1_pc2", {24'd0, pc}, 2);
      cycle(); chk("t1_pc3", {24'd0, pc}, 3);
      cycle(); chk("t1_cnt3", {16'd0, insn_cnt}, 3);

      // JNO with ex_busy stall, not taken -> falls to... taken since flag_eq=0
      fill_default();
      mem[1] = {OP_JNO, 4'h0, 8'd6};
      ir_ready = 1; flag_eq = 0; ex_busy = 1;
      start();
      cycle(); chk("t2_pc_e1", {24'd0, pc}, 1);
      cycle(); chk("t2_valid_wait", {31'd0, ir_valid}, 0);
      for (int k = 0; k < 3; k++) begin
         cycle(); chk("t2_pc_hold", {24'd0, pc}, 1);
      end
      ex_busy = 0;
      cycle(); chk("t2_pc_tgt", {24'd0, pc}, 6);
      cycle(); chk("t2_ir6", {16'd0, ir}, 32'h1006);

      // JNZ not taken: one WAIT cycle then pc+1
      fill_default();
      mem[5] = {OP_JNZ, 4'h0, 8'd77};
      flag_eq = 0; ex_busy = 0; ir_ready = 1;
      start();
      repeat (5) cycle();
      chk("t3_pc5", {24'd0, pc}, 5);
      cycle(); chk("t3_pc_held", {24'd0, pc}, 5);
      cycle(); chk("t3_pc6", {24'd0, pc}, 6);

      // JNZ taken into a self-jump, then frozen
      fill_default();
      mem[0]  = {OP_JNZ, 4'h0, 8'd77};
      mem[78] = {OP_JMP, 4'h0, 8'd78};
      flag_eq = 1;
      start();
      cycle(); cycle(); chk("t4_pc77", {24'd0, pc}, 77);
      cycle(); chk("t4_ir77", {16'd0, ir}, 32'h104D);
      cycle();
      chk("t4_halted", {31'd0, halted}, 1);
      chk("t4_pc78", {24'd0, pc}, 78);
      chk("t4_cnt", {16'd0, insn_cnt}, 1);
      for (int k = 0; k < 100; k++) begin
         ir_ready = 1'($urandom_range(0, 1));
         ex_busy  = 1'($urandom_range(0, 1));
         flag_eq  = 1'($urandom_range(0, 1));
         cycle();
      end
      chk("t4_pc_frozen", {24'd0, pc}, 78);
      chk("t4_cnt_frozen", {16'd0, insn_cnt}, 1);
      chk("t4_still_halted", {31'd0, halted}, 1);

      // decode back-pressure: nothing lost or duplicated
      fill_default();
      ir_ready = 1; ex_busy = 0; flag_eq = 0;
      start();
      repeat (3) cycle();
      ir_ready = 0;
      repeat (5) cycle();
      chk("t5_pc_stall", {24'd0, pc}, 3);
      chk("t5_ir_stall", {16'd0, ir}, 32'h1002);
      chk("t5_valid_stall", {31'd0, ir_valid}, 1);
      ir_ready = 1;
      repeat (5) cycle();
      chk("t5_xfer_count", dq.size(), 7);
      for (int k = 0; k < dq.size(); k++)
         chk("t5_xfer_order", {16'd0, dq[k]}, 32'h1000 + k);

      // asynchronous reset in the middle of WAIT
      fill_default();
      mem[17] = {OP_JNZ, 4'h0, 8'd40};
      ex_busy = 1; ir_ready = 1;
      start();
      repeat (19) cycle();
      chk("t6_pc17", {24'd0, pc}, 17);
      chk("t6_wait_valid", {31'd0, ir_valid}, 0);
      #2;
      rst = 1;
      #1;
      model_reset();
      chk("t6_async_pc", {24'd0, pc}, 0);
      chk("t6_async_ir", {16'd0, ir}, 0);
      chk("t6_async_cnt", {16'd0, insn_cnt}, 0);
      cycle();
      rst = 0; ex_busy = 0;
      cycle();
      chk("t6_first_pc", {24'd0, pc}, 1);
      chk("t6_first_ir", {16'd0, ir}, 32'h1000);

      // pc wraps 255 -> 0
      fill_default();
      start();
      repeat (260) cycle();
      chk("t7_wrap", {24'd0, pc}, 4);

      // randomized programs and handshakes
      for (int s = 0; s < 8; s++) begin
         for (int i = 0; i < 256; i++) begin
            int r;
            logic [7:0] t;
            r = $urandom_range(0, 99);
            t = ($urandom_range(0, 3) == 0) ? 8'(i) : 8'($urandom_range(0, 255));
            if (r < 60)      mem[i] = {4'($urandom_range(0, 7)), 12'($urandom)};
            else if (r < 75) mem[i] = {OP_JNZ, 4'($urandom), t};
            else if (r < 88) mem[i] = {OP_JNO, 4'($urandom), t};
            else             mem[i] = {OP_JMP, 4'($urandom), t};
         end
         start();
         for (int k = 0; k < 400; k++) begin
            ir_ready = ($urandom_range(0, 3) != 0);
            ex_busy  = ($urandom_range(0, 2) == 0);
            flag_eq  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 149) == 0) begin
               do_reset();
               cycle();
               rst = 0;
            end
            cycle();
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock.
REQ-002 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port pc  output  8  instruction address to the combinational instruction memory.
REQ-004 SHALL have port op_in  input  16  instruction word returned for pc, same cycle.
REQ-005 SHALL have port ir  output  16  registered instruction to decode.
REQ-006 SHALL have port ir_valid  output  1  ir holds an instruction not yet accepted.
REQ-007 SHALL have port ir_ready  input  1  decode accepts ir this cycle.
REQ-008 SHALL have port ex_busy  input  1  downstream holds an unretired instruction, so flag_eq is not final.
REQ-009 SHALL have port flag_eq  input  1  result of the last retired COMP/CHECK: 1 means equal.
REQ-010 SHALL have port halted  output  1  program reached a self-jump.
REQ-011 SHALL have port insn_cnt  output  16  count of instructions handed to decode.

Function
REQ-012 Opcode field SHALL be op_in[15:12] and branch target SHALL be op_in[7:0].
REQ-013 SHALL have states RUN, WAIT, HALT.
REQ-014 Transfer SHALL occur when ir_valid and ir_ready are both 1; ir SHALL stay stable while ir_valid=1 and ir_ready=0.
REQ-015 In RUN, the unit SHALL fetch only when slot_free = (!ir_valid or ir_ready).
REQ-016 RUN, slot_free, non-branch opcode: ir<=op_in, ir_valid<=1, pc<=pc+1 (8-bit wrap, 255->0), one-cycle latency pc->ir.
REQ-017 RUN, slot_free, JMP with target!=pc: pc<=target, ir_valid<=0; JMP SHALL never reach decode.
REQ-018 RUN, slot_free, JMP with target==pc: go to HALT, halted<=1, ir_valid<=0, pc held.
REQ-019 RUN, slot_free, JNZ or JNO: latch target and branch type, pc held, ir_valid<=0, go to WAIT.
REQ-020 RUN, !slot_free: pc, ir and state SHALL hold.
REQ-021 WAIT: remain in WAIT while ex_busy=1; ir_valid SHALL be 0.
REQ-022 WAIT, ex_busy=0: taken = (JNZ and flag_eq=1) or (JNO and flag_eq=0); pc<=taken ? target : pc+1; go to RUN next cycle.
REQ-023 A conditional branch whose target equals its own pc and is taken SHALL enter HALT.
REQ-024 HALT SHALL be left only by rst; pc, ir, and insn_cnt SHALL freeze; ir_valid SHALL be 0 once any pending ir is accepted.
REQ-025 insn_cnt SHALL increment on each transfer and saturate at 16'hFFFF.
REQ-026 halted SHALL be registered and asserted from the first HALT cycle.

Reset
REQ-027 rst=1 SHALL immediately force pc=0, ir=0, ir_valid=0, halted=0, insn_cnt=0, state=RUN.
REQ-028 rst asserted during WAIT or HALT SHALL discard the latched branch; the first fetch after release SHALL be address 0.
REQ-029 The first rising edge with rst=0 SHALL perform the normal RUN fetch of address 0.

Structure
REQ-030 Opcode constants (JMP, JNZ, JNO, COMP, CHECK, ...) SHALL come from the shared opcode definitions header and SHALL NOT be redefined locally.
REQ-031 State encodings SHALL be local parameters of fetch_unit.
REQ-032 One combinational sub-module branch_classify SHALL map op_in to is_jmp, is_jnz, is_jno and target; everything else SHALL be flat.

Verification
REQ-033 Reset, then program 0:COMP, 1:INC, 2:DEC with ir_ready=1 -> ir_valid high from cycle 1, pc 0,1,2,3, insn_cnt=3 after three transfers.
REQ-034 At 1:JNO 6, ex_busy=1 for 3 cycles then 0, flag_eq=0 -> pc holds at 1 for 4 cycles, then pc=6, JNO never on ir.
REQ-035 At 5:JNZ 77 with flag_eq=0 and ex_busy=0 -> pc=6 two cycles after fetch of 5, no bubble beyond WAIT.
REQ-036 At 78:JMP 78 -> halted=1 next cycle, pc stays 78, insn_cnt frozen across 100 cycles.
REQ-037 ir_ready=0 for 5 cycles with ir_valid=1 -> ir and pc unchanged, no instruction lost or duplicated after release.
REQ-038 rst pulsed mid-WAIT at pc=17 -> outputs cleared asynchronously, first fetch after release is pc=0.
